// File: rtl/kasumi_pkg.sv
// ============================================================================
// Module : kasumi_pkg
// Brief  : Shared MEM-stage definitions: command fields, funct3 codes, FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kasumi_pkg;

    localparam int MEM_ACCESS = 0;
    localparam int MEM_WRITE  = 1;
    localparam int MEM_F3_LSB = 2;
    localparam int MEM_F3_MSB = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    // Stores only come in signed-free widths; loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        if (is_write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_extract.sv
// ============================================================================
// Module : mem_load_extract
// Brief  : Selects the load lane from a read word and sign/zero extends it.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_extract
    import kasumi_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_B:    ext_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ext_data = {24'd0, w_byte};
            F3_H:    ext_data = {{16{w_half[15]}}, w_half};
            F3_HU:   ext_data = {16'd0, w_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// Module : memory_access
// Brief  : RV32I MEM stage; req/ack data-memory bus with lane alignment.
//          Optional misaligned-access trap: KASUMI_MISALIGN_TRAP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access
    import kasumi_pkg::*;
#(
    parameter int DMEM_ADDR_W = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stop,
    input  logic                   bubble,
    input  logic [4:0]             in_mem_command,
    input  logic [4:0]             in_reg_d,
    input  logic [31:0]            in_alu_out,
    input  logic [31:0]            in_mem_write_data,
    input  logic [31:0]            in_now_pc,
    output logic                   mem_busy,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_wstrb,
    input  logic                   dmem_ack,
    input  logic [31:0]            dmem_rdata,
    output logic [4:0]             out_reg_d,
    output logic [31:0]            out_wb_data,
    output logic [31:0]            out_now_pc,
    output logic                   misalign_trap
);

    mem_state_t  r_state;
    logic [2:0]  r_f3;
    logic [1:0]  r_a_lo;
    logic [4:0]  r_rd;
    logic [31:0] r_hold_data;
    logic        r_trap;

    logic        w_access;
    logic        w_write;
    logic [2:0]  w_f3;
    logic        w_f3_ok;
    logic        w_misaligned;
    logic [1:0]  w_a_lo;
    logic        w_issue;
    logic        w_fault;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_ext_src;
    logic [31:0] w_load_data;

    assign w_access = in_mem_command[MEM_ACCESS];
    assign w_write  = in_mem_command[MEM_WRITE];
    assign w_f3     = in_mem_command[MEM_F3_MSB:MEM_F3_LSB];
    assign w_f3_ok  = f3_legal(w_write, w_f3);

`ifdef KASUMI_MISALIGN_TRAP_EN
    assign w_misaligned = ((w_f3[1:0] == 2'b01) && in_alu_out[0]) ||
                          ((w_f3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
    assign w_a_lo       = in_alu_out[1:0];
`else
    // Without the trap, low address bits are dropped to the access width.
    assign w_misaligned = 1'b0;
    always_comb begin
        w_a_lo = in_alu_out[1:0];
        case (w_f3[1:0])
            2'b01:   w_a_lo = {in_alu_out[1], 1'b0};
            2'b10:   w_a_lo = 2'b00;
            default: w_a_lo = in_alu_out[1:0];
        endcase
    end
`endif

    assign w_issue = w_access && w_f3_ok && !w_misaligned;
    assign w_fault = w_access && w_f3_ok && w_misaligned;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = in_mem_write_data;
        case (w_f3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << w_a_lo;
                w_wdata = {4{in_mem_write_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {w_a_lo[1], 1'b0};
                w_wdata = {2{in_mem_write_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = in_mem_write_data;
            end
        endcase
        if (!w_write)
            w_wstrb = 4'b0000;
    end

    assign mem_busy = ((r_state == IDLE) && !stop && !bubble && w_issue) ||
                      ((r_state == REQ)  && !dmem_ack) ||
                      ((r_state == HOLD) && stop);

    // One extractor serves both the live ack path and the stalled HOLD path.
    assign w_ext_src = (r_state == HOLD) ? r_hold_data : dmem_rdata;

    mem_load_extract u_extract (
        .funct3   (r_f3),
        .addr_lo  (r_a_lo),
        .rdata    (w_ext_src),
        .ext_data (w_load_data)
    );

    assign misalign_trap = r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_f3        <= 3'd0;
            r_a_lo      <= 2'd0;
            r_rd        <= 5'd0;
            r_hold_data <= 32'd0;
            r_trap      <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= 32'd0;
            dmem_wstrb  <= 4'd0;
            out_reg_d   <= 5'd0;
            out_wb_data <= 32'd0;
            out_now_pc  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stop) begin
                        r_trap     <= 1'b0;
                        out_now_pc <= in_now_pc;
                        if (bubble) begin
                            out_reg_d   <= 5'd0;
                            out_wb_data <= 32'd0;
                        end else if (!w_access) begin
                            out_reg_d   <= in_reg_d;
                            out_wb_data <= in_alu_out;
                        end else if (w_issue) begin
                            dmem_req    <= 1'b1;
                            dmem_we     <= w_write;
                            dmem_addr   <= in_alu_out[2 +: DMEM_ADDR_W];
                            dmem_wdata  <= w_wdata;
                            dmem_wstrb  <= w_wstrb;
                            r_f3        <= w_f3;
                            r_a_lo      <= w_a_lo;
                            r_rd        <= w_write ? 5'd0 : in_reg_d;
                            out_reg_d   <= 5'd0;
                            out_wb_data <= 32'd0;
                            r_state     <= REQ;
                        end else begin
                            out_reg_d   <= 5'd0;
                            out_wb_data <= w_fault ? in_alu_out : 32'd0;
                            r_trap      <= w_fault;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (stop) begin
                            r_hold_data <= dmem_rdata;
                            r_state     <= HOLD;
                        end else begin
                            out_reg_d   <= r_rd;
                            out_wb_data <= dmem_we ? 32'd0 : w_load_data;
                            r_state     <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!stop) begin
                        out_reg_d   <= r_rd;
                        out_wb_data <= dmem_we ? 32'd0 : w_load_data;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
